// File: rtl/disp_vramrd_pkg.sv
// Shared constants for the display VRAM read master: resolution codes,
// per-resolution burst counts per frame, and the burst length.
package disp_vramrd_pkg;

   typedef logic [1:0] resol_t;

   localparam int C_BURST_LEN = 16;

   localparam resol_t P_RESOL_VGA  = 2'b00;
   localparam resol_t P_RESOL_XGA  = 2'b01;
   localparam resol_t P_RESOL_SXGA = 2'b10;

   // One burst carries 32 pixels (16 beats x 2 pixels)
   localparam int P_BURSTS_VGA  = 9600;
   localparam int P_BURSTS_XGA  = 24576;
   localparam int P_BURSTS_SXGA = 40960;

   // Reserved code 11 falls back to VGA
   function automatic int bursts_for(input resol_t resol, input int vga, input int xga,
                                     input int sxga);
      case (resol)
         P_RESOL_XGA:  return xga;
         P_RESOL_SXGA: return sxga;
         default:      return vga;
      endcase
   endfunction

endpackage

// File: rtl/disp_vramrd.sv
// AXI4 read master that fetches one frame of pixels per VSTART into the pixel FIFO.
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | no frame in progress, waiting for VSTART with DISPON
// WAIT_ROOM | between bursts, waiting until the FIFO can take a burst
// ADDR      | raising ARVALID, then holding it until ARREADY
// DATA      | accepting beats into the FIFO until RLAST
module disp_vramrd
   import disp_vramrd_pkg::*;
#(
   parameter int C_AXI_DATA_WIDTH = 64,
   parameter int C_BURST_LEN      = disp_vramrd_pkg::C_BURST_LEN,
   parameter int C_CNT_WIDTH      = 16,
   parameter int C_BURSTS_VGA     = P_BURSTS_VGA,
   parameter int C_BURSTS_XGA     = P_BURSTS_XGA,
   parameter int C_BURSTS_SXGA    = P_BURSTS_SXGA
) (
   input  logic                        ACLK,
   input  logic                        ARESETN,
   input  logic                        DISPON,
   input  logic [31:0]                 DISPADDR,
   input  logic [1:0]                  RESOL,
   input  logic                        VSTART,
   output logic [31:0]                 ARADDR,
   output logic [7:0]                  ARLEN,
   output logic                        ARVALID,
   input  logic                        ARREADY,
   input  logic [C_AXI_DATA_WIDTH-1:0] RDATA,
   input  logic                        RLAST,
   input  logic                        RVALID,
   output logic                        RREADY,
   input  logic                        FIFO_FULL,
   output logic                        FIFO_WREN,
   output logic [C_AXI_DATA_WIDTH-1:0] FIFO_WDATA,
   output logic                        BUSY
);

   localparam logic [1:0] S_IDLE      = 2'd0;
   localparam logic [1:0] S_WAIT_ROOM = 2'd1;
   localparam logic [1:0] S_ADDR      = 2'd2;
   localparam logic [1:0] S_DATA      = 2'd3;

   localparam logic [31:0] BURST_BYTES = 32'(C_BURST_LEN * (C_AXI_DATA_WIDTH / 8));

   logic [1:0]             state_q;
   logic [31:0]            araddr_q;
   logic                   arvalid_q;
   logic                   rready_q;
   logic                   busy_q;
   logic [C_CNT_WIDTH-1:0] remaining_q;
   logic [C_CNT_WIDTH-1:0] frame_bursts;

   assign frame_bursts = C_CNT_WIDTH'(bursts_for(RESOL, C_BURSTS_VGA, C_BURSTS_XGA,
                                                 C_BURSTS_SXGA));

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state_q     <= S_IDLE;
         araddr_q    <= '0;
         arvalid_q   <= 1'b0;
         rready_q    <= 1'b0;
         busy_q      <= 1'b0;
         remaining_q <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (VSTART && DISPON) begin
                  araddr_q    <= DISPADDR & 32'hFFFF_FF80;
                  remaining_q <= frame_bursts;
                  busy_q      <= 1'b1;
                  state_q     <= S_WAIT_ROOM;
               end
            end
            S_WAIT_ROOM: begin
               if (!FIFO_FULL) state_q <= S_ADDR;
            end
            S_ADDR: begin
               // First ADDR cycle raises ARVALID; handshake only counts once it is up
               if (!arvalid_q) begin
                  arvalid_q <= 1'b1;
               end else if (ARREADY) begin
                  arvalid_q <= 1'b0;
                  rready_q  <= 1'b1;
                  state_q   <= S_DATA;
               end
            end
            default: begin
               if (RVALID && RLAST) begin
                  rready_q    <= 1'b0;
                  araddr_q    <= araddr_q + BURST_BYTES;
                  remaining_q <= remaining_q - C_CNT_WIDTH'(1);
                  if (remaining_q == C_CNT_WIDTH'(1) || !DISPON) begin
                     busy_q  <= 1'b0;
                     state_q <= S_IDLE;
                  end else begin
                     state_q <= S_WAIT_ROOM;
                  end
               end
            end
         endcase
      end
   end

   assign ARADDR     = araddr_q;
   assign ARLEN      = 8'(C_BURST_LEN - 1);
   assign ARVALID    = arvalid_q;
   assign RREADY     = rready_q;
   assign BUSY       = busy_q;
   assign FIFO_WREN  = RVALID && rready_q;
   assign FIFO_WDATA = RDATA;

endmodule
